// File: rtl/mgmt_hub.sv
// mgmt_hub: routes one mgmt master to N_SLV slaves by address field,
// answers misses/timeouts with MISS_DATA and keeps sticky error flags.
// Ports: clk, rstn; master mgmt_req/adr/rwn/wen/txd -> mgmt_ack/rxe/rxd;
// slaves s_req -> s_ack/s_rxe/s_rxd; err_clr -> err {spur, timeout, miss}.
module mgmt_hub #(
  parameter int          N_SLV     = 5,
  parameter int          SEL_LSB   = 12,
  parameter int          SEL_W     = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] MISS_DATA = 32'hDEAD_0BAD
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mgmt_req,
  input  logic [31:0]           mgmt_adr,
  input  logic                  mgmt_rwn,
  input  logic [1:0]            mgmt_wen,
  input  logic [31:0]           mgmt_txd,
  output logic                  mgmt_ack,
  output logic                  mgmt_rxe,
  output logic [31:0]           mgmt_rxd,
  output logic [N_SLV-1:0]      s_req,
  input  logic [N_SLV-1:0]      s_ack,
  input  logic [N_SLV-1:0]      s_rxe,
  input  logic [32*N_SLV-1:0]   s_rxd,
  input  logic                  err_clr,
  output logic [2:0]            err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] T_SAT = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, WAIT_ACK, WAIT_RXD, MISS
  } state_t;

  state_t           state;
  logic [N_SLV-1:0] sel_oh;
  logic [N_SLV-1:0] adr_oh;
  logic [N_SLV-1:0] exp_ack;
  logic [N_SLV-1:0] exp_rxe;
  logic [SEL_W-1:0] adr_sel;
  logic [TW-1:0]    timer;
  logic [31:0]      sel_rxd;
  logic [2:0]       err_set;
  logic             rwn_q;
  logic             pend;
  logic             accept;
  logic             ack_hit;
  logic             rxe_hit;
  logic             t_fire;
  logic             spur;
  logic             unused;

  // Address/data/enables reach the slaves on their own wires.
  assign unused = ^{mgmt_wen, mgmt_txd, mgmt_adr};

  always_comb begin
    adr_sel = mgmt_adr[SEL_LSB +: SEL_W];
    for (int i = 0; i < N_SLV; i++) begin
      adr_oh[i] = (adr_sel == SEL_W'(i));
    end
    sel_rxd = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_oh[i]) sel_rxd = s_rxd[32*i +: 32];
    end
    accept  = (state == IDLE) && mgmt_req && !mgmt_ack;
    ack_hit = |(s_ack & sel_oh);
    rxe_hit = |(s_rxe & sel_oh);
    t_fire  = (TIMEOUT != 0) && (timer == T_LAST);
    // Only the awaited (state, slave) response is legal.
    exp_ack = '0;
    exp_rxe = '0;
    case (state)
      WAIT_ACK: begin
        exp_ack = sel_oh;
        if (ack_hit && rwn_q) exp_rxe = sel_oh;
      end
      WAIT_RXD: if (!pend) exp_rxe = sel_oh;
      default: ;
    endcase
    spur = (|(s_ack & ~exp_ack)) || (|(s_rxe & ~exp_rxe));
    err_set[0] = accept && !(|adr_oh);
    err_set[1] = t_fire &&
      (((state == WAIT_ACK) && !ack_hit) ||
       ((state == WAIT_RXD) && !pend && !rxe_hit));
    err_set[2] = spur;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sel_oh   <= '0;
      rwn_q    <= 1'b0;
      pend     <= 1'b0;
      timer    <= '0;
      s_req    <= '0;
      mgmt_ack <= 1'b0;
      mgmt_rxe <= 1'b0;
      mgmt_rxd <= '0;
      err      <= '0;
    end else begin
      mgmt_ack <= 1'b0;
      mgmt_rxe <= 1'b0;
      err      <= (err_clr ? 3'b000 : err) | err_set;
      case (state)
        IDLE: if (accept) begin
          sel_oh <= adr_oh;
          rwn_q  <= mgmt_rwn;
          pend   <= 1'b0;
          timer  <= '0;
          if (|adr_oh) begin
            s_req <= adr_oh;
            state <= WAIT_ACK;
          end else begin
            mgmt_ack <= 1'b1;
            state    <= MISS;
          end
        end
        MISS: begin
          if (rwn_q) begin
            mgmt_rxe <= 1'b1;
            mgmt_rxd <= MISS_DATA;
          end
          state <= IDLE;
        end
        WAIT_ACK: begin
          if (ack_hit) begin
            s_req    <= '0;
            mgmt_ack <= 1'b1;
            if (!rwn_q) begin
              state <= IDLE;
            end else begin
              state <= WAIT_RXD;
              timer <= '0;
              // Data arriving with the ack is replayed next cycle.
              if (rxe_hit) begin
                mgmt_rxd <= sel_rxd;
                pend     <= 1'b1;
              end
            end
          end else if (t_fire) begin
            s_req    <= '0;
            mgmt_ack <= 1'b1;
            if (rwn_q) begin
              mgmt_rxd <= MISS_DATA;
              pend     <= 1'b1;
              state    <= WAIT_RXD;
            end else begin
              state <= IDLE;
            end
          end else if (timer != T_SAT) begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_RXD: begin
          if (pend) begin
            mgmt_rxe <= 1'b1;
            pend     <= 1'b0;
            state    <= IDLE;
          end else if (rxe_hit) begin
            mgmt_rxe <= 1'b1;
            mgmt_rxd <= sel_rxd;
            state    <= IDLE;
          end else if (t_fire) begin
            mgmt_rxe <= 1'b1;
            mgmt_rxd <= MISS_DATA;
            state    <= IDLE;
          end else if (timer != T_SAT) begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_hub.sv
// tb_mgmt_hub: table-driven transactions against mgmt_hub plus
// hand sequences for spurious responses and mid-transaction reset.
module tb_mgmt_hub;

  localparam logic [31:0] MD = 32'hDEAD_0BAD;

  logic         clk = 1'b0;
  logic         rstn;
  logic         mgmt_req;
  logic [31:0]  mgmt_adr;
  logic         mgmt_rwn;
  logic [1:0]   mgmt_wen;
  logic [31:0]  mgmt_txd;
  logic         mgmt_ack;
  logic         mgmt_rxe;
  logic [31:0]  mgmt_rxd;
  logic [4:0]   s_req;
  logic [4:0]   s_ack;
  logic [4:0]   s_rxe;
  logic [159:0] s_rxd;
  logic         err_clr;
  logic [2:0]   err;

  int n_chk = 0;
  int n_bad = 0;

  mgmt_hub #(
    .N_SLV(5), .SEL_LSB(12), .SEL_W(4),
    .TIMEOUT(8), .MISS_DATA(MD)
  ) dut (
    .clk(clk), .rstn(rstn),
    .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr),
    .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen),
    .mgmt_txd(mgmt_txd), .mgmt_ack(mgmt_ack),
    .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
    .s_req(s_req), .s_ack(s_ack), .s_rxe(s_rxe),
    .s_rxd(s_rxd), .err_clr(err_clr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic        rwn;
    int          ack_dly;
    int          rxe_dly;
    logic [31:0] rdata;
    logic [4:0]  exp_sreq;
    int          exp_cnt;
    int          exp_ack_at;
    int          exp_rxe_at;
    logic [31:0] exp_rxd;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(
    string nm, logic [31:0] adr, logic rwn,
    int ad, int rd, logic [31:0] dat,
    logic [4:0] es, int ec, int ea, int er,
    logic [31:0] ed, logic [2:0] ee);
    vec_t v;
    v.name = nm; v.adr = adr; v.rwn = rwn;
    v.ack_dly = ad; v.rxe_dly = rd; v.rdata = dat;
    v.exp_sreq = es; v.exp_cnt = ec;
    v.exp_ack_at = ea; v.exp_rxe_at = er;
    v.exp_rxd = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // One master transaction with a slave model that acks in its
  // ack_dly-th request cycle and returns data rxe_dly cycles later.
  task automatic run_vec(input vec_t v);
    int          sel_i;
    int          cnt;
    int          ack_n;
    int          ack_at;
    int          rxe_n;
    int          rxe_at;
    int          given;
    logic [4:0]  sreq_or;
    logic [31:0] rxd_got;
    sel_i = int'(v.adr[15:12]);
    cnt = 0; ack_n = 0; ack_at = 0;
    rxe_n = 0; rxe_at = 0; given = -1;
    sreq_or = '0; rxd_got = '0;
    mgmt_adr = v.adr;
    mgmt_rwn = v.rwn;
    mgmt_wen = v.rwn ? 2'b00 : 2'b11;
    mgmt_txd = $urandom;
    mgmt_req = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      s_ack = '0;
      s_rxe = '0;
      sreq_or |= s_req;
      if (s_req != '0) cnt++;
      if (mgmt_ack) begin
        ack_n++; ack_at = j; mgmt_req = 1'b0;
      end
      if (mgmt_rxe) begin
        rxe_n++; rxe_at = j; rxd_got = mgmt_rxd;
      end
      if (sel_i < 5) begin
        if (s_req[sel_i] && cnt == v.ack_dly) begin
          s_ack[sel_i] = 1'b1;
          given = j;
        end
        if (given >= 0 && v.rxe_dly >= 0 &&
            j == given + v.rxe_dly) begin
          s_rxe[sel_i] = 1'b1;
          s_rxd[32*sel_i +: 32] = v.rdata;
        end
      end
    end
    chk({v.name, ".sreq"}, 32'(sreq_or), 32'(v.exp_sreq));
    chk({v.name, ".sreq_cyc"}, cnt, v.exp_cnt);
    chk({v.name, ".ack_n"}, ack_n, 1);
    chk({v.name, ".ack_at"}, ack_at, v.exp_ack_at);
    if (v.exp_rxe_at != 0) begin
      chk({v.name, ".rxe_n"}, rxe_n, 1);
      chk({v.name, ".rxe_at"}, rxe_at, v.exp_rxe_at);
      chk({v.name, ".rxd"}, rxd_got, v.exp_rxd);
    end else begin
      chk({v.name, ".rxe_n"}, rxe_n, 0);
    end
    chk({v.name, ".err"}, 32'(err), 32'(v.exp_err));
    clr_err();
    chk({v.name, ".err_clr"}, 32'(err), 32'd0);
  endtask

  initial begin
    int quiet;
    vecs[0] = mk("wr_s2", 32'h0000_2010, 0, 3, -1, 0,
                 5'b00100, 3, 4, 0, 0, 3'b000);
    vecs[1] = mk("rd_s4", 32'h0000_4000, 1, 2, 5,
                 32'h1234_5678, 5'b10000, 2, 3, 8,
                 32'h1234_5678, 3'b000);
    vecs[2] = mk("rd_miss", 32'h0000_7000, 1, 1, 1, 0,
                 5'b00000, 0, 1, 2, MD, 3'b001);
    vecs[3] = mk("wr_miss", 32'h0000_F004, 0, 1, 1, 0,
                 5'b00000, 0, 1, 0, 0, 3'b001);
    vecs[4] = mk("rd_to_ack", 32'h0000_1000, 1, -1, -1, 0,
                 5'b00010, 8, 9, 10, MD, 3'b010);
    vecs[5] = mk("wr_to_ack", 32'h0000_0ABC, 0, -1, -1, 0,
                 5'b00001, 8, 9, 0, 0, 3'b010);
    vecs[6] = mk("rd_same", 32'h0000_3000, 1, 1, 0,
                 32'hA5A5_0003, 5'b01000, 1, 2, 3,
                 32'hA5A5_0003, 3'b000);
    vecs[7] = mk("wr_s0_fast", 32'hABCD_0004, 0, 1, -1, 0,
                 5'b00001, 1, 2, 0, 0, 3'b000);
    vecs[8] = mk("rd_to_rxd", 32'h0000_2000, 1, 1, -1, 0,
                 5'b00100, 1, 2, 10, MD, 3'b010);

    rstn = 1'b0; mgmt_req = 1'b0; mgmt_adr = '0;
    mgmt_rwn = 1'b0; mgmt_wen = '0; mgmt_txd = '0;
    s_ack = '0; s_rxe = '0; err_clr = 1'b0;
    s_rxd = {5{32'h5A5A_5A5A}};
    tick();
    tick();
    chk("rst.sreq", 32'(s_req), 0);
    chk("rst.ack", 32'(mgmt_ack), 0);
    chk("rst.rxe", 32'(mgmt_rxe), 0);
    chk("rst.rxd", mgmt_rxd, 0);
    chk("rst.err", 32'(err), 0);
    rstn = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Multi-hot read data while waiting on slave 3.
    mgmt_adr = 32'h0000_3000; mgmt_rwn = 1'b1;
    mgmt_req = 1'b1;
    tick();
    chk("spur.sreq", 32'(s_req), 32'h8);
    s_ack = 5'b01000;
    tick();
    s_ack = '0;
    chk("spur.ack", 32'(mgmt_ack), 1);
    mgmt_req = 1'b0;
    s_rxe = 5'b01001;
    s_rxd[31:0] = 32'h0BAD_0000;
    s_rxd[127:96] = 32'h3333_3333;
    tick();
    s_rxe = '0;
    chk("spur.rxe", 32'(mgmt_rxe), 1);
    chk("spur.rxd", mgmt_rxd, 32'h3333_3333);
    chk("spur.err", 32'(err), 32'h4);
    clr_err();
    chk("spur.clr", 32'(err), 0);

    // Stray ack in IDLE.
    s_ack = 5'b00010;
    tick();
    s_ack = '0;
    chk("idle_ack.ack", 32'(mgmt_ack), 0);
    chk("idle_ack.err", 32'(err), 32'h4);
    tick();
    chk("idle_ack.ack2", 32'(mgmt_ack), 0);
    clr_err();

    // Reset while waiting for read data from slave 4.
    mgmt_adr = 32'h0000_4000; mgmt_rwn = 1'b1;
    mgmt_req = 1'b1;
    tick();
    s_ack = 5'b10000;
    tick();
    s_ack = '0;
    mgmt_req = 1'b0;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst.sreq", 32'(s_req), 0);
    chk("mid_rst.rxd", mgmt_rxd, 0);
    chk("mid_rst.rxe", 32'(mgmt_rxe), 0);
    s_rxe = 5'b10000;
    tick();
    s_rxe = '0;
    rstn = 1'b1;
    quiet = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (mgmt_ack || mgmt_rxe || s_req != '0) quiet++;
    end
    chk("mid_rst.quiet", quiet, 0);
    chk("mid_rst.err", 32'(err), 0);
    run_vec(mk("rd_after_rst", 32'h0000_4008, 1, 1, 1,
               32'hCAFE_F00D, 5'b10000, 1, 2, 3,
               32'hCAFE_F00D, 3'b000));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
